uart_burst_tx: RTL



---
 rtl/uart_burst_tx.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_burst_tx.sv
// uart_burst_tx
// Burst UART transmitter. A one-cycle sent_trig_i pulse latches data_length_i
// and the block then reads that many bytes from a byte buffer (addresses
// 0 .. length-1, one-cycle read latency) and sends each one as an 8N1 frame
// on uart_tx_o. A one-cycle done_o pulse marks the end of the burst.
//
// Optional build macro: UART_BURST_TX_PARITY_EN
//   defined   - an even-parity bit is sent after the data bits (8E1 frames)
//   undefined - 8N1 frames only
//
// Ports
//   S_AXI_ACLK     in   system clock, rising edge
//   S_AXI_ARESET   in   asynchronous active-high reset
//   data_length_i  in   [9:0] byte count, sampled on an accepted trigger
//   sent_trig_i    in   single-cycle start pulse
//   buf_addr_o     out  [9:0] byte buffer read address
//   buf_rd_o       out  buffer read strobe, one cycle per byte
//   buf_data_i     in   [7:0] buffer data, valid one cycle after buf_rd_o
//   uart_tx_o      out  serial line, idle high
//   busy_o         out  high from trigger acceptance until burst end
//   done_o         out  one-cycle pulse at burst end
//   byte_cnt_o     out  [9:0] bytes fully transmitted in current/last burst
module uart_burst_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESET,
    input  logic [9:0] data_length_i,
    input  logic       sent_trig_i,
    output logic [9:0] buf_addr_o,
    output logic       buf_rd_o,
    input  logic [7:0] buf_data_i,
    output logic       uart_tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [9:0] byte_cnt_o
);

`ifdef UART_BURST_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd6
    } state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_BURST_TX_PARITY_EN
    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    logic       par_r;
`endif

    state_t      state_r;
    state_t      state_s;
    logic [15:0] baud_r;
    logic [2:0]  bit_r;
    logic [7:0]  shift_r;
    logic [9:0]  len_r;
    logic [9:0]  addr_r;
    logic [9:0]  cnt_r;
    logic        rd_r;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;
    logic        fin_r;
    logic        bit_end_s;
    logic        last_byte_s;
    logic        timed_s;
    logic        accept_s;

    assign bit_end_s   = (baud_r == BAUD_LAST);
    assign last_byte_s = ((cnt_r + 10'd1) == len_r);
    assign timed_s     = (state_r != IDLE) && (state_r != FETCH) && (state_r != WAIT);
    // busy_r is still high in IDLE for the single cycle while the final
    // stop bit drains from the line; triggers are ignored then too.
    assign accept_s    = (state_r == IDLE) && sent_trig_i && !busy_r &&
                         (data_length_i != 10'd0);

    // State register.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = FETCH;
                else          state_s = IDLE;
            end
            FETCH: state_s = WAIT;
            WAIT:  state_s = START;
            START: begin
                if (bit_end_s) state_s = DATA;
                else           state_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_r == 3'd7)) begin
`ifdef UART_BURST_TX_PARITY_EN
                    state_s = PARITY;
`else
                    state_s = STOP;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_BURST_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) state_s = STOP;
                else           state_s = PARITY;
            end
`endif
            STOP: begin
                if (bit_end_s) state_s = last_byte_s ? IDLE : FETCH;
                else           state_s = STOP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs. The serial line is driven from the
    // current state, so it trails the state by one cycle; done/busy are
    // delayed one cycle via fin_r to line up with the end of the stop bit.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            baud_r  <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            len_r   <= 10'd0;
            addr_r  <= 10'd0;
            cnt_r   <= 10'd0;
            rd_r    <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fin_r   <= 1'b0;
`ifdef UART_BURST_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            rd_r   <= (state_s == FETCH);
            done_r <= 1'b0;
            fin_r  <= 1'b0;

            if (timed_s && !bit_end_s) baud_r <= baud_r + 16'd1;
            else                       baud_r <= 16'd0;

            case (state_r)
                IDLE: begin
                    if (sent_trig_i && !busy_r) begin
                        if (data_length_i == 10'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            len_r  <= data_length_i;
                            cnt_r  <= 10'd0;
                            addr_r <= 10'd0;
                            busy_r <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    shift_r <= buf_data_i;
                    bit_r   <= 3'd0;
`ifdef UART_BURST_TX_PARITY_EN
                    par_r   <= even_parity(buf_data_i);
`endif
                end
                DATA: begin
                    if (bit_end_s) begin
                        shift_r <= {1'b0, shift_r[7:1]};
                        bit_r   <= bit_r + 3'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= cnt_r + 10'd1;
                        if (last_byte_s) fin_r  <= 1'b1;
                        else             addr_r <= addr_r + 10'd1;
                    end
                end
                default: begin
                end
            endcase

            if (fin_r) begin
                done_r <= 1'b1;
                busy_r <= 1'b0;
            end

            case (state_r)
                START:   tx_r <= 1'b0;
                DATA:    tx_r <= shift_r[0];
`ifdef UART_BURST_TX_PARITY_EN
                PARITY:  tx_r <= par_r;
`endif
                default: tx_r <= 1'b1;
            endcase
        end
    end

    assign buf_addr_o = addr_r;
    assign buf_rd_o   = rd_r;
    assign uart_tx_o  = tx_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign byte_cnt_o = cnt_r;

endmodule
